// File: rtl/filter_loader.sv
// Loads a four-row, 32-bit-per-row filter from word memory into a row buffer.
// Optional byte checksum output enabled by defining FILTER_LOADER_CHKSUM_EN.
module filter_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_data,
  output logic              buf_we,
  output logic [1:0]        buf_row,
  output logic [31:0]       buf_wdata,
  output logic              buf_re,
  output logic              busy,
`ifdef FILTER_LOADER_CHKSUM_EN
  output logic              done,
  output logic [11:0]       chksum
`else
  output logic              done
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt;
  logic [2:0]        row_m1;
  logic [ADDR_W-1:0] base_q;
  logic              accept;

  assign accept = (state == IDLE) && start;
  // Write of row r lands one cycle after its read issue, so the write row trails the issue count.
  assign row_m1 = cnt - 3'd1;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: each always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   if (cnt == 3'd3) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      base_q <= '0;
      buf_re <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt    <= '0;
          base_q <= base_addr;
          buf_re <= 1'b0;
        end
        FETCH: cnt <= cnt + 3'd1;
        DRAIN: begin
          cnt    <= cnt + 3'd1;
          buf_re <= 1'b1;
        end
        DONE:    cnt <= '0;
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_addr  = '0;
    buf_we    = 1'b0;
    buf_row   = '0;
    buf_wdata = '0;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + ADDR_W'(cnt);
        if (cnt != 3'd0) begin
          buf_we  = 1'b1;
          buf_row = row_m1[1:0];
        end
      end
      DRAIN: begin
        buf_we  = 1'b1;
        buf_row = row_m1[1:0];
      end
      default: ;
    endcase
    if (buf_we) buf_wdata = mem_data;
  end

`ifdef FILTER_LOADER_CHKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum <= '0;
    end else if (accept) begin
      chksum <= '0;
    end else if (buf_we) begin
      chksum <= chksum + 12'(buf_wdata[7:0]) + 12'(buf_wdata[15:8])
                       + 12'(buf_wdata[23:16]) + 12'(buf_wdata[31:24]);
    end
  end
`endif

endmodule

// File: tb/tb_filter_loader.sv
// Directed self-checking bench for filter_loader; checksum checks follow FILTER_LOADER_CHKSUM_EN.
module tb_filter_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        mem_rd;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data = 32'h0;
  logic        buf_we;
  logic [1:0]  buf_row;
  logic [31:0] buf_wdata;
  logic        buf_re;
  logic        busy;
  logic        done;
`ifdef FILTER_LOADER_CHKSUM_EN
  logic [11:0] chksum;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [256];

  filter_loader #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .buf_we    (buf_we),
    .buf_row   (buf_row),
    .buf_wdata (buf_wdata),
    .buf_re    (buf_re),
    .busy      (busy),
`ifdef FILTER_LOADER_CHKSUM_EN
    .done      (done),
    .chksum    (chksum)
`else
    .done      (done)
`endif
  );

  always #5 clk = ~clk;

  // Memory with one-cycle read latency; junk data when no read was issued.
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 32'hDEAD_BEEF;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_rd"},    32'(mem_rd),    32'h0);
    check({tag, " mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, " buf_we"},    32'(buf_we),    32'h0);
    check({tag, " buf_row"},   32'(buf_row),   32'h0);
    check({tag, " buf_wdata"}, buf_wdata,      32'h0);
    check({tag, " buf_re"},    32'(buf_re),    32'h0);
    check({tag, " busy"},      32'(busy),      32'h0);
    check({tag, " done"},      32'(done),      32'h0);
`ifdef FILTER_LOADER_CHKSUM_EN
    check({tag, " chksum"},    32'(chksum),    32'h0);
`endif
  endtask

  // Launches a load and checks cycles T0+1..T0+6; returns at the negedge of the done cycle.
  task automatic run_load(input logic [7:0] base, input bit hold_start, input string tag);
    logic        e_rd, e_we;
    logic [7:0]  e_addr;
    logic [1:0]  e_row;
    logic [31:0] e_wd;
    @(negedge clk);
    start     = 1'b1;
    base_addr = base;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (!hold_start) start = 1'b0;
      e_rd   = (k <= 4);
      e_addr = e_rd ? base + 8'(k - 1) : 8'h00;
      e_we   = (k >= 2) && (k <= 5);
      e_row  = e_we ? 2'(k - 2) : 2'd0;
      e_wd   = e_we ? mem[base + 8'(k - 2)] : 32'h0;
      check($sformatf("%s k%0d mem_rd", tag, k),    32'(mem_rd),   32'(e_rd));
      check($sformatf("%s k%0d mem_addr", tag, k),  32'(mem_addr), 32'(e_addr));
      check($sformatf("%s k%0d buf_we", tag, k),    32'(buf_we),   32'(e_we));
      check($sformatf("%s k%0d buf_row", tag, k),   32'(buf_row),  32'(e_row));
      check($sformatf("%s k%0d buf_wdata", tag, k), buf_wdata,     e_wd);
      check($sformatf("%s k%0d busy", tag, k),      32'(busy),     32'h1);
      check($sformatf("%s k%0d done", tag, k),      32'(done),     32'(k == 6));
      check($sformatf("%s k%0d buf_re", tag, k),    32'(buf_re),   32'(k == 6));
    end
  endtask

  initial begin
    int n_rd, n_done;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h10] = 32'h0403_0201;
    mem[8'h11] = 32'h0807_0605;
    mem[8'h12] = 32'h0C0B_0A09;
    mem[8'h13] = 32'h100F_0E0D;
    mem[8'hFE] = 32'hA1A2_A3A4;
    mem[8'hFF] = 32'hB1B2_B3B4;
    mem[8'h00] = 32'hC1C2_C3C4;
    mem[8'h01] = 32'hD1D2_D3D4;
    for (int i = 8'h40; i < 8'h44; i++) mem[i] = 32'hFFFF_FFFF;

    rst = 1'b1; start = 1'b1; base_addr = 8'h10;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0; start = 1'b0;

    // Basic load
    run_load(8'h10, 1'b0, "basic");
`ifdef FILTER_LOADER_CHKSUM_EN
    check("basic chksum", 32'(chksum), 32'h088);
`endif
    @(negedge clk);
    check("basic idle buf_re", 32'(buf_re), 32'h1);
    check("basic idle busy",   32'(busy),   32'h0);
    check("basic idle done",   32'(done),   32'h0);
`ifdef FILTER_LOADER_CHKSUM_EN
    check("basic chksum held", 32'(chksum), 32'h088);
`endif

    // Address wrap
    run_load(8'hFE, 1'b0, "wrap");

    // Start pulsed while busy is ignored
    @(negedge clk);
    start = 1'b1; base_addr = 8'h10;
    @(posedge clk);
    n_rd = 0; n_done = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = (k == 3);
      if (mem_rd) n_rd++;
      if (done)   n_done++;
    end
    check("busy_start mem_rd count", 32'(n_rd),   32'd4);
    check("busy_start done count",   32'(n_done), 32'd1);

    // Mid-load reset aborts and clears everything asynchronously
    @(negedge clk);
    start = 1'b1; base_addr = 8'h10;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst pre mem_rd", 32'(mem_rd), 32'h1);
    #1 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst post buf_re", 32'(buf_re), 32'h0);
    check("midrst post busy",   32'(busy),   32'h0);
    run_load(8'h10, 1'b0, "after_rst");
`ifdef FILTER_LOADER_CHKSUM_EN
    check("after_rst chksum", 32'(chksum), 32'h088);
`endif

    // Back-to-back with start held high
    run_load(8'h40, 1'b1, "b2b1");
    @(negedge clk);
    check("b2b k7 mem_rd", 32'(mem_rd), 32'h0);
    check("b2b k7 busy",   32'(busy),   32'h0);
    check("b2b k7 buf_re", 32'(buf_re), 32'h1);
    @(negedge clk);
    start = 1'b0;
    check("b2b k8 mem_rd",   32'(mem_rd),   32'h1);
    check("b2b k8 mem_addr", 32'(mem_addr), 32'h40);
    check("b2b k8 buf_re",   32'(buf_re),   32'h0);
    check("b2b k8 busy",     32'(busy),     32'h1);
    n_done = 0;
    for (int k = 9; k <= 13; k++) begin
      @(negedge clk);
      if (done) n_done++;
      if (k == 13) check("b2b k13 done", 32'(done), 32'h1);
    end
    check("b2b second done count", 32'(n_done), 32'd1);
    check("b2b buf_re after", 32'(buf_re), 32'h1);
`ifdef FILTER_LOADER_CHKSUM_EN
    check("b2b chksum max", 32'(chksum), 32'hFF0);
`endif

    // All-0xFF load
    run_load(8'h40, 1'b0, "max");
`ifdef FILTER_LOADER_CHKSUM_EN
    check("max chksum", 32'(chksum), 32'hFF0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/filter_loader.md
FILTER_LOADER -- requirements
Module: filter_loader

Interface
REQ-001 Parameter ADDR_W, default 8: width of the memory word address.
REQ-002 Port clk, input, 1: sole clock; all state updates on posedge.
REQ-003 Port rst, input, 1: reset; one clock; reset is asynchronous and active-high.
REQ-004 Port start, input, 1: load request; sampled only in IDLE.
REQ-005 Port base_addr, input, ADDR_W: word address of filter row 0; latched on accepted start.
REQ-006 Port mem_rd, output, 1: memory read strobe.
REQ-007 Port mem_addr, output, ADDR_W: memory word address.
REQ-008 Port mem_data, input, 32: read data, valid exactly one cycle after mem_rd.
REQ-009 Port buf_we, output, 1: filter buffer row write enable.
REQ-010 Port buf_row, output, 2: filter buffer row index.
REQ-011 Port buf_wdata, output, 32: row data, byte 0 in [7:0] up to byte 3 in [31:24].
REQ-012 Port buf_re, output, 1: filter buffer read enable; high means the buffer holds a complete filter.
REQ-013 Port busy, output, 1: high from the cycle after an accepted start through the done cycle.
REQ-014 Port done, output, 1: one-cycle completion pulse.
REQ-015 Port chksum, output, 12: byte sum of the loaded filter; present only per REQ-032.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DRAIN and DONE, with a 3-bit row/issue counter.
REQ-017 IDLE -> FETCH on start=1 at posedge T0; base_addr latched; buf_re cleared at T0+1.
REQ-018 In FETCH, cycles T0+1..T0+4 SHALL assert mem_rd with mem_addr = base + r, r = 0..3.
REQ-019 Address addition SHALL wrap modulo 2^ADDR_W, with no carry out.
REQ-020 Cycles T0+2..T0+5 SHALL assert buf_we with buf_row = r and buf_wdata = mem_data (direct pass, zero added latency).
REQ-021 FETCH -> DRAIN after the 4th read issue; DRAIN covers the final write at T0+5; DRAIN -> DONE.
REQ-022 DONE at T0+6: done=1 for exactly one cycle, buf_re set to 1, then -> IDLE.
REQ-023 buf_re SHALL stay 1 in IDLE until the next accepted start or reset.
REQ-024 start while busy SHALL be ignored, with no queuing; start held high in IDLE with done seen SHALL relaunch at the next IDLE cycle.
REQ-025 Total load latency SHALL be 6 cycles from the accepted-start edge to done.
REQ-026 mem_addr, buf_row and buf_wdata SHALL be 0 whenever their strobe is low.

Reset
REQ-027 On rst=1 the state SHALL go immediately to IDLE with the counter at 0.
REQ-028 While rst=1, mem_rd, buf_we, buf_re, busy and done SHALL all be 0.
REQ-029 While rst=1, mem_addr, buf_row, buf_wdata and chksum SHALL all be 0.
REQ-030 Reset mid-load SHALL abort the load; buf_re stays 0 until a full load completes.
REQ-031 The first start is accepted at the first posedge after rst deasserts.

Configuration
REQ-032 Macro FILTER_LOADER_CHKSUM_EN controls the checksum feature.
REQ-033 With FILTER_LOADER_CHKSUM_EN defined, chksum SHALL be cleared on accepted start.
REQ-034 With FILTER_LOADER_CHKSUM_EN defined, chksum SHALL accumulate the four bytes of each buf_we row, unsigned.
REQ-035 With FILTER_LOADER_CHKSUM_EN defined, chksum SHALL be final when done=1 and held until the next start.
REQ-036 Without FILTER_LOADER_CHKSUM_EN, the chksum port and its logic SHALL be absent.

Verification
REQ-037 Basic load: base=0x10, mem[0x10..0x13]=0x04030201,0x08070605,0x0C0B0A09,0x100F0E0D -> writes rows 0..3 with those words at T0+2..T0+5, done at T0+6, buf_re=1, chksum=0x088.
REQ-038 Wrap: ADDR_W=8, base=0xFE -> mem_addr sequence 0xFE,0xFF,0x00,0x01.
REQ-039 Busy start: start pulsed at T0+3 -> ignored, exactly 4 mem_rd, one done pulse.
REQ-040 Mid-load reset: rst at T0+3 -> all outputs 0 asynchronously, buf_re=0; next start -> full 6-cycle load.
REQ-041 Back-to-back: start held high -> second load's first mem_rd at T0+8, buf_re drops at T0+8.
REQ-042 Checksum max: all bytes 0xFF with macro defined -> chksum=0xFF0; without macro -> port absent, elaborates.
